// File: rtl/aud_play_dsp_if.sv
// SRAM read port between the playback DSP (master) and the recording SRAM (slave).
interface aud_play_dsp_if #(
  parameter int unsigned ADDR_W = 20
);
  logic [ADDR_W-1:0] o_sram_addr;
  logic [15:0]       i_sram_data;

  modport master (output o_sram_addr, input  i_sram_data);
  modport slave  (input  o_sram_addr, output i_sram_data);
endinterface

// File: rtl/aud_play_dsp.sv
// Playback DSP: fetches 16-bit samples from SRAM once per DACLRCK frame and applies
// normal / fast skip / slow hold / slow linear-interpolation speed control.
// Optional feature macro: AUD_PLAY_LINEAR_INTERP_EN (slow_1 interpolates; otherwise
// slow_1 behaves as slow_0 and the multiplier and reciprocal table are absent).
module aud_play_dsp #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow_0,
  input  logic              i_slow_1,
  input  logic [2:0]        i_speed,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_end_addr,
  aud_play_dsp_if.master    sram,
  output logic [15:0]       o_dac_data,
  output logic              o_done,
  output logic              o_playing
);
  localparam int unsigned CMP_W = ADDR_W + 4;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSE} state_e;
  typedef enum logic [1:0] {M_NORM, M_FAST, M_SLOW0, M_SLOW1} mode_e;

`ifdef AUD_PLAY_LINEAR_INTERP_EN
  localparam mode_e SLOW1_MODE = M_SLOW1;
`else
  localparam mode_e SLOW1_MODE = M_SLOW0;
`endif

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d, mode_c;
  logic               lrc_q, tick_c;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [2:0]         k_q, k_d, k_c;
  logic signed [15:0] prev_q, prev_d, cur_c;
  logic               last_q, last_d, done_q, done_d, play_q, play_d;
  logic [15:0]        dac_q, dac_d;
  logic [2:0]         vld_q, vld_d;
  logic               launch_c, adv_c, slow_c, clr_c;
  logic [3:0]         step_c;
  logic [CMP_W-1:0]   nxt_c;
  logic signed [15:0] out3_q;

  assign tick_c = i_daclrck & ~lrc_q;
  assign cur_c  = sram.i_sram_data;

  // Effective mode for this tick (s=0 forces normal) and k cleared on mode change
  always_comb begin
    mode_c = M_NORM;
    if (i_speed == 3'd0)  mode_c = M_NORM;
    else if (i_fast)      mode_c = M_FAST;
    else if (i_slow_1)    mode_c = SLOW1_MODE;
    else if (i_slow_0)    mode_c = M_SLOW0;
    k_c    = (mode_c != mode_q) ? 3'd0 : k_q;
    slow_c = (mode_c == M_SLOW0) || (mode_c == M_SLOW1);
    adv_c  = !slow_c || (k_c >= i_speed);
    step_c = (mode_c == M_FAST) ? 4'(i_speed) + 4'd1 : 4'd1;
    nxt_c  = CMP_W'(addr_q) + CMP_W'(step_c);
  end

  // Next-state and register updates for play control, address and k
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    k_d      = k_q;
    prev_d   = prev_q;
    last_d   = last_q;
    done_d   = 1'b0;
    launch_c = 1'b0;
    clr_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!i_stop && i_start) begin
          state_d = ST_PLAY;
          mode_d  = mode_c;
          clr_c   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else if (tick_c) begin
          if (last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            clr_c   = 1'b1;
          end else begin
            launch_c = 1'b1;
            mode_d   = mode_c;
            k_d      = (slow_c && !adv_c) ? 3'(k_c + 3'd1) : 3'd0;
            if (adv_c) begin
              if (nxt_c > CMP_W'(i_end_addr)) last_d = 1'b1;
              else                            addr_d = nxt_c[ADDR_W-1:0];
              if (mode_c == M_SLOW1) prev_d = cur_c;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end else if (i_start) begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_c) begin
      addr_d = '0;
      k_d    = 3'd0;
      prev_d = 16'sd0;
      last_d = 1'b0;
    end
    play_d = (state_d == ST_PLAY);
    // Leaving PLAY silences the output and drops samples still in flight
    vld_d  = play_d ? {vld_q[1:0], launch_c} : 3'b000;
    dac_d  = !play_d ? 16'd0 : (vld_q[2] ? 16'(out3_q) : dac_q);
  end

  // Control state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= M_NORM;
      lrc_q   <= 1'b0;
      addr_q  <= '0;
      k_q     <= 3'd0;
      prev_q  <= 16'sd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      play_q  <= 1'b0;
      vld_q   <= 3'b000;
      dac_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lrc_q   <= i_daclrck;
      addr_q  <= addr_d;
      k_q     <= k_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      done_q  <= done_d;
      play_q  <= play_d;
      vld_q   <= vld_d;
      dac_q   <= dac_d;
    end
  end

`ifdef AUD_PLAY_LINEAR_INTERP_EN
  logic signed [15:0] base_c, base1_q, base2_q, sat_c;
  logic [2:0]         kmul_c;
  logic signed [16:0] diff_c;
  logic signed [20:0] diff_x, k_x, dk_c, dk1_q;
  logic [16:0]        r1_q;
  logic signed [38:0] dk_w, r_w, prod_c, prod2_q, sum_c;

  // Reciprocal table: round(65536/N) indexed by s = N-1
  function automatic logic [16:0] rlut(input logic [2:0] s);
    case (s)
      3'd0:    return 17'd65536;
      3'd1:    return 17'd32768;
      3'd2:    return 17'd21845;
      3'd3:    return 17'd16384;
      3'd4:    return 17'd13107;
      3'd5:    return 17'd10923;
      3'd6:    return 17'd9362;
      default: return 17'd8192;
    endcase
  endfunction

  // Non-interpolating modes run through the same datapath with k=0 and base=cur
  always_comb begin
    base_c = (mode_c == M_SLOW1) ? prev_q : cur_c;
    kmul_c = (mode_c == M_SLOW1) ? k_c : 3'd0;
    diff_c = 17'(cur_c) - 17'(prev_q);
    diff_x = 21'(diff_c);
    k_x    = 21'(kmul_c);
    dk_c   = diff_x * k_x;
    dk_w   = 39'(dk1_q);
    r_w    = 39'(r1_q);
    prod_c = dk_w * r_w;
    sum_c  = 39'(base2_q) + (prod2_q >>> 16);
    if (sum_c > 39'sd32767)       sat_c = 16'sh7fff;
    else if (sum_c < -39'sd32768) sat_c = 16'sh8000;
    else                          sat_c = sum_c[15:0];
  end

  // Three-stage interpolation pipeline: diff*k, *R, shift/add/saturate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base1_q <= 16'sd0;
      dk1_q   <= 21'sd0;
      r1_q    <= 17'd0;
      base2_q <= 16'sd0;
      prod2_q <= 39'sd0;
      out3_q  <= 16'sd0;
    end else begin
      if (launch_c) begin
        base1_q <= base_c;
        dk1_q   <= dk_c;
        r1_q    <= rlut(i_speed);
      end
      base2_q <= base1_q;
      prod2_q <= prod_c;
      out3_q  <= sat_c;
    end
  end
`else
  logic signed [15:0] smp1_q, smp2_q;

  // Plain delay line keeps the same tick-to-output latency
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smp1_q <= 16'sd0;
      smp2_q <= 16'sd0;
      out3_q <= 16'sd0;
    end else begin
      if (launch_c) smp1_q <= cur_c;
      smp2_q <= smp1_q;
      out3_q <= smp2_q;
    end
  end
`endif

  assign sram.o_sram_addr = addr_q;
  assign o_dac_data       = dac_q;
  assign o_done           = done_q;
  assign o_playing        = play_q;
endmodule
